switch_input_port: RTL and testbench

Input-side peripheral for the processor: samples the board switches, synchronizes and debounces them, and turns each accepted level change into a latched event the CPU reads with a one-cycle strobe. It is the counterpart of the LED/7-segment output path: physical inputs toward `computer` rather than register values out to the board. It sits between the raw `sw1..sw4` pins and the CPU input bus, clocked by the same clock as the CPU.

---
 rtl/io_pkg.sv | 19 +
 rtl/sw_debounce.sv | 67 ++++++
 rtl/switch_input_port.sv | 89 ++++++++
 tb/tb_switch_input_port.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// io_pkg: shared constants and state enums for the
// switch input path (event field offsets, debounce states).
package io_pkg;

  localparam int EVT_STATE_LSB    = 0;
  localparam int EVT_MASK_LSB     = 4;
  localparam int DEBOUNCE_DEFAULT = 16;

  typedef enum logic {
    STABLE,
    COUNTING
  } db_state_t;

  typedef enum logic {
    EMPTY,
    PENDING
  } evt_state_t;

endpackage

// File: rtl/sw_debounce.sv
// sw_debounce: one switch; 2-flop sync plus debounce FSM.
// Ports: clk, rst, sw_raw in; level (accepted), changed (1-cycle pulse) out.
module sw_debounce
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_raw,
  output logic level,
  output logic changed
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  db_state_t     state;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= sw_raw;
      sync2 <= sync1;
    end
  end

  // The edge that enters COUNTING is count 1, so acceptance
  // happens when the count already shows DEBOUNCE_CYCLES-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= STABLE;
      cnt     <= '0;
      level   <= 1'b0;
      changed <= 1'b0;
    end else begin
      changed <= 1'b0;
      unique case (state)
        STABLE: begin
          if (sync2 != level) begin
            state <= COUNTING;
            cnt   <= CW'(1);
          end
        end
        COUNTING: begin
          if (sync2 == level) begin
            state <= STABLE;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            level   <= sync2;
            changed <= 1'b1;
            state   <= STABLE;
            cnt     <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/switch_input_port.sv
// switch_input_port: debounced switches to a latched CPU event.
// Ports: clk, rst, sw_raw, rd_req in; sw_state, event_valid, event_data, overflow out.
module switch_input_port
  import io_pkg::*;
#(
  parameter int N_SW            = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_SW-1:0] sw_raw,
  input  logic            rd_req,
  output logic [N_SW-1:0] sw_state,
  output logic            event_valid,
  output logic [7:0]      event_data,
  output logic            overflow
);

  logic [N_SW-1:0] changed;
  logic [3:0]      chg4;
  logic [3:0]      st4;
  logic [3:0]      mask_q;
  logic [3:0]      st_q;
  logic            any_chg;
  evt_state_t      evt_state;

  for (genvar i = 0; i < N_SW; i++) begin : g_sw
    sw_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk    (clk),
      .rst    (rst),
      .sw_raw (sw_raw[i]),
      .level  (sw_state[i]),
      .changed(changed[i])
    );
  end

  always_comb begin
    chg4 = '0;
    st4  = '0;
    chg4[N_SW-1:0] = changed;
    st4[N_SW-1:0]  = sw_state;
  end

  assign any_chg = |changed;

  // A read that lands with a new change consumes the old
  // event; the new one starts fresh instead of merging.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_state <= EMPTY;
      mask_q    <= '0;
      st_q      <= '0;
      overflow  <= 1'b0;
    end else begin
      unique case (evt_state)
        EMPTY: begin
          if (any_chg) begin
            evt_state <= PENDING;
            mask_q    <= chg4;
            st_q      <= st4;
            overflow  <= 1'b0;
          end
        end
        PENDING: begin
          if (rd_req) begin
            overflow <= 1'b0;
            if (any_chg) begin
              mask_q <= chg4;
              st_q   <= st4;
            end else begin
              evt_state <= EMPTY;
            end
          end else if (any_chg) begin
            mask_q   <= mask_q | chg4;
            st_q     <= st4;
            overflow <= 1'b1;
          end
        end
      endcase
    end
  end

  assign event_valid = (evt_state == PENDING);
  assign event_data[EVT_MASK_LSB +: 4]  = mask_q;
  assign event_data[EVT_STATE_LSB +: 4] = st_q;

endmodule

// File: tb/tb_switch_input_port.sv
// tb_switch_input_port: directed bench with event scoreboard.
// Drives sw_raw/rd_req/rst; checks sw_state and event outputs.
module tb_switch_input_port;

  logic       clk;
  logic       rst;
  logic [3:0] sw_raw;
  logic       rd_req;
  logic [3:0] sw_state;
  logic       event_valid;
  logic [7:0] event_data;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  logic [8:0] exp_q[$];
  logic       prev_v = 1'b0;
  logic [7:0] prev_d = 8'h00;

  switch_input_port #(
    .N_SW(4),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sw_raw     (sw_raw),
    .rd_req     (rd_req),
    .sw_state   (sw_state),
    .event_valid(event_valid),
    .event_data (event_data),
    .overflow   (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // Advance one edge, sample 1 time unit later, and score
  // any new event (valid rising, or data change while valid).
  task automatic tick();
    logic [8:0] e;
    @(posedge clk);
    #1;
    if (event_valid &&
        (!prev_v || event_data != prev_d)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_event observed %0h expected none",
               event_data);
      end else begin
        e = exp_q.pop_front();
        chk("evt_data", {24'h0, event_data}, {24'h0, e[7:0]});
        chk("evt_ovf", {31'h0, overflow}, {31'h0, e[8]});
      end
    end
    prev_v = event_valid;
    prev_d = event_data;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic read_pulse();
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
  endtask

  initial begin
    rst    = 1'b0;
    sw_raw = 4'h0;
    rd_req = 1'b0;
    #1 rst = 1'b1;
    #2;
    chk("rst_state", {28'h0, sw_state}, 32'h0);
    chk("rst_valid", {31'h0, event_valid}, 32'h0);
    chk("rst_data", {24'h0, event_data}, 32'h0);
    chk("rst_ovf", {31'h0, overflow}, 32'h0);
    ticks(2);
    rst = 1'b0;
    tick();

    // read while idle: no effect
    read_pulse();
    tick();
    chk("idle_rd_valid", {31'h0, event_valid}, 32'h0);
    chk("idle_rd_data", {24'h0, event_data}, 32'h0);
    chk("idle_rd_ovf", {31'h0, overflow}, 32'h0);

    // clean press of sw0
    sw_raw = 4'b0001;
    exp_q.push_back({1'b0, 8'h11});
    ticks(5);
    chk("press_e5_state", {28'h0, sw_state}, 32'h0);
    tick();
    chk("press_e6_state", {28'h0, sw_state}, 32'h1);
    chk("press_e6_valid", {31'h0, event_valid}, 32'h0);
    tick();
    chk("press_e7_valid", {31'h0, event_valid}, 32'h1);
    chk("press_e7_data", {24'h0, event_data}, 32'h11);
    read_pulse();
    chk("press_rd_valid", {31'h0, event_valid}, 32'h0);
    chk("press_rd_hold", {24'h0, event_data}, 32'h11);
    sw_raw = 4'b0000;
    exp_q.push_back({1'b0, 8'h10});
    ticks(8);
    read_pulse();

    // bounce on sw1, then settle high
    for (int i = 0; i < 12; i++) begin
      sw_raw[1] = ((i / 2) % 2 == 0);
      tick();
    end
    chk("bounce_state", {28'h0, sw_state}, 32'h0);
    sw_raw[1] = 1'b1;
    exp_q.push_back({1'b0, 8'h22});
    ticks(6);
    chk("bounce_e6_valid", {31'h0, event_valid}, 32'h0);
    tick();
    chk("bounce_e7_data", {24'h0, event_data}, 32'h22);
    read_pulse();
    sw_raw[1] = 1'b0;
    exp_q.push_back({1'b0, 8'h20});
    ticks(8);
    read_pulse();

    // overflow: two presses without a read
    sw_raw = 4'b0001;
    exp_q.push_back({1'b0, 8'h11});
    ticks(8);
    sw_raw = 4'b0101;
    exp_q.push_back({1'b1, 8'h55});
    ticks(7);
    chk("ovf_data", {24'h0, event_data}, 32'h55);
    chk("ovf_flag", {31'h0, overflow}, 32'h1);
    read_pulse();
    chk("ovf_rd_valid", {31'h0, event_valid}, 32'h0);
    chk("ovf_rd_flag", {31'h0, overflow}, 32'h0);

    // simultaneous release of sw0 and sw2
    sw_raw = 4'b0000;
    exp_q.push_back({1'b0, 8'h50});
    ticks(8);
    chk("multi_data", {24'h0, event_data}, 32'h50);
    read_pulse();

    // read collides with a new change
    sw_raw = 4'b0001;
    exp_q.push_back({1'b0, 8'h11});
    ticks(8);
    sw_raw = 4'b0000;
    exp_q.push_back({1'b0, 8'h10});
    ticks(6);
    read_pulse();
    chk("coll_valid", {31'h0, event_valid}, 32'h1);
    chk("coll_data", {24'h0, event_data}, 32'h10);
    chk("coll_ovf", {31'h0, overflow}, 32'h0);

    // reset mid-count with an event pending
    sw_raw = 4'b1000;
    ticks(4);
    #3 rst = 1'b1;
    #1;
    chk("mrst_valid", {31'h0, event_valid}, 32'h0);
    chk("mrst_data", {24'h0, event_data}, 32'h0);
    chk("mrst_state", {28'h0, sw_state}, 32'h0);
    tick();
    rst = 1'b0;
    exp_q.push_back({1'b0, 8'h88});
    ticks(5);
    chk("mrst_e5_state", {28'h0, sw_state}, 32'h0);
    tick();
    chk("mrst_e6_state", {28'h0, sw_state}, 32'h8);
    tick();
    chk("mrst_e7_valid", {31'h0, event_valid}, 32'h1);
    chk("mrst_e7_data", {24'h0, event_data}, 32'h88);
    read_pulse();
    chk("mrst_rd_valid", {31'h0, event_valid}, 32'h0);

    chk("queue_empty", exp_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
